// File: rtl/bip_seq_control.sv
// Sequencer for a basic instruction processor: fetch/decode/execute FSM,
// program counter and instruction register, decoding opcodes into datapath controls.
module bip_seq_control #(
    parameter int NB_BITS       = 16,
    parameter int NB_OPC        = 5,
    parameter int INS_MEM_DEPTH = 2048,
    localparam int NB_ADDR      = $clog2(INS_MEM_DEPTH),
    localparam int NB_OPND      = NB_BITS - NB_OPC
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_BITS-1:0] i_instruction,
    input  logic               i_acc_zero,
    input  logic               i_mem_ready,
    output logic [NB_ADDR-1:0] o_addr_ins,
    output logic               o_ins_en,
    output logic [NB_OPND-1:0] o_data_ins,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_wr_acc,
    output logic               o_op_code,
    output logic               o_wr,
    output logic               o_rd,
    output logic               o_halted,
    output logic               o_busy
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_t;

    localparam logic [NB_OPC-1:0] OP_HALT = NB_OPC'(0);
    localparam logic [NB_OPC-1:0] OP_STO  = NB_OPC'(1);
    localparam logic [NB_OPC-1:0] OP_LD   = NB_OPC'(2);
    localparam logic [NB_OPC-1:0] OP_LDI  = NB_OPC'(3);
    localparam logic [NB_OPC-1:0] OP_ADD  = NB_OPC'(4);
    localparam logic [NB_OPC-1:0] OP_ADDI = NB_OPC'(5);
    localparam logic [NB_OPC-1:0] OP_SUB  = NB_OPC'(6);
    localparam logic [NB_OPC-1:0] OP_SUBI = NB_OPC'(7);
    localparam logic [NB_OPC-1:0] OP_JMP  = NB_OPC'(8);
    localparam logic [NB_OPC-1:0] OP_BEQ  = NB_OPC'(9);
    localparam logic [NB_OPC-1:0] OP_BNE  = NB_OPC'(10);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic [NB_BITS-1:0] ir_q, ir_d;
    logic [NB_ADDR-1:0] pc_inc, target;
    logic [NB_OPC-1:0]  opc;

    assign opc        = ir_q[NB_BITS-1 -: NB_OPC];
    assign o_addr_ins = pc_q;
    assign o_data_ins = ir_q[NB_OPND-1:0];
    assign o_halted   = (state_q == S_HALTED);
    assign o_busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    // Explicit compare so non-power-of-two depths also wrap at the last word.
    assign pc_inc     = (pc_q == NB_ADDR'(INS_MEM_DEPTH - 1)) ? '0 : pc_q + NB_ADDR'(1);

    generate
        if (NB_OPND >= NB_ADDR) begin : g_tgt_trunc
            assign target = ir_q[NB_ADDR-1:0];
        end else begin : g_tgt_zext
            assign target = {{(NB_ADDR - NB_OPND){1'b0}}, ir_q[NB_OPND-1:0]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        o_ins_en  = 1'b0;
        o_sel_a   = 2'b00;
        o_sel_b   = 1'b0;
        o_wr_acc  = 1'b0;
        o_op_code = 1'b0;
        o_wr      = 1'b0;
        o_rd      = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) state_d = S_FETCH;
            S_FETCH: begin
                o_ins_en = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = i_instruction;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opc)
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALTED;
                    end
                    OP_STO: begin
                        o_sel_a = 2'b11;
                        o_wr    = 1'b1;
                    end
                    OP_LD: begin
                        o_wr_acc = i_mem_ready;
                        o_rd     = 1'b1;
                    end
                    OP_LDI: begin
                        o_sel_a  = 2'b01;
                        o_wr_acc = 1'b1;
                    end
                    OP_ADD: begin
                        o_sel_a   = 2'b10;
                        o_wr_acc  = i_mem_ready;
                        o_op_code = 1'b1;
                        o_rd      = 1'b1;
                    end
                    OP_ADDI: begin
                        o_sel_a   = 2'b10;
                        o_sel_b   = 1'b1;
                        o_wr_acc  = 1'b1;
                        o_op_code = 1'b1;
                    end
                    OP_SUB: begin
                        o_sel_a  = 2'b10;
                        o_wr_acc = i_mem_ready;
                        o_rd     = 1'b1;
                    end
                    OP_SUBI: begin
                        o_sel_a  = 2'b10;
                        o_sel_b  = 1'b1;
                        o_wr_acc = 1'b1;
                    end
                    OP_JMP: pc_d = target;
                    OP_BEQ: pc_d = i_acc_zero ? target : pc_inc;
                    OP_BNE: pc_d = i_acc_zero ? pc_inc : target;
                    default: ;
                endcase
                // Memory-bound ops park in EXEC with controls held until the data memory answers.
                if ((opc == OP_STO || opc == OP_LD || opc == OP_ADD || opc == OP_SUB) && !i_mem_ready) begin
                    pc_d    = pc_q;
                    state_d = S_EXEC;
                end
            end
            S_HALTED: begin
                if (i_start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bip_seq_control.sv
// Directed bench for bip_seq_control with a 16-word instruction memory model.
module tb_bip_seq_control;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_acc_zero, i_mem_ready;
    logic [15:0] i_instruction = '0;
    logic [3:0]  o_addr_ins;
    logic        o_ins_en;
    logic [10:0] o_data_ins;
    logic [1:0]  o_sel_a;
    logic        o_sel_b, o_wr_acc, o_op_code, o_wr, o_rd, o_halted, o_busy;
    logic [6:0]  ctl;
    logic [15:0] imem [16];
    int          n_chk = 0;
    int          n_pass = 0;

    bip_seq_control #(.NB_BITS(16), .NB_OPC(5), .INS_MEM_DEPTH(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_instruction(i_instruction), .i_acc_zero(i_acc_zero), .i_mem_ready(i_mem_ready),
        .o_addr_ins(o_addr_ins), .o_ins_en(o_ins_en), .o_data_ins(o_data_ins),
        .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_wr_acc(o_wr_acc), .o_op_code(o_op_code),
        .o_wr(o_wr), .o_rd(o_rd), .o_halted(o_halted), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous-read instruction memory: data appears the cycle after o_ins_en.
    always @(posedge i_clk) if (o_ins_en) i_instruction <= imem[o_addr_ins];

    assign ctl = {o_sel_a, o_sel_b, o_wr_acc, o_op_code, o_wr, o_rd};

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opnd);
        return {op, opnd};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Entered in FETCH; checks fetch and decode cycles and leaves the bench in EXEC.
    task automatic to_exec(input string tag, input logic [3:0] exp_addr);
        chk({tag, "_fetch_en"}, o_ins_en, 1);
        chk({tag, "_fetch_addr"}, o_addr_ins, exp_addr);
        chk({tag, "_fetch_ctl"}, ctl, 0);
        tick();
        chk({tag, "_decode"}, {o_busy, o_ins_en, ctl}, {2'b10, 7'd0});
        tick();
        chk({tag, "_exec_busy"}, o_busy, 1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_acc_zero = 1'b0; i_mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = '0;
        imem[0]  = ins(5'b00011, 11'd5);      // LDI 5
        imem[1]  = ins(5'b00101, 11'd3);      // ADDI 3
        imem[2]  = ins(5'b00000, 11'd0);      // HALT
        repeat (2) tick();
        chk("rst_busy_halted", {o_busy, o_halted}, 0);
        chk("rst_addr", o_addr_ins, 0);
        chk("rst_ctl", {o_ins_en, ctl}, 0);
        chk("rst_data", o_data_ins, 0);
        i_rst_n = 1'b1;
        tick();
        chk("idle_no_fetch", {o_busy, o_ins_en}, 0);

        // LDI 5; ADDI 3; HALT
        i_start = 1'b1; tick(); i_start = 1'b0;
        to_exec("ldi", 4'd0);
        chk("ldi_ctl", ctl, 7'b01_0_1_0_0_0);
        chk("ldi_data", o_data_ins, 11'd5);
        tick();
        to_exec("addi", 4'd1);
        chk("addi_ctl", ctl, 7'b10_1_1_1_0_0);
        chk("addi_data", o_data_ins, 11'd3);
        tick();
        to_exec("halt", 4'd2);
        chk("halt_ctl", ctl, 0);
        tick();
        chk("halted_flag", {o_halted, o_busy}, 2'b10);
        chk("halted_pc", o_addr_ins, 4'd2);
        tick();
        chk("halted_stays", {o_halted, o_ins_en}, 2'b10);

        // LD with three wait cycles, then branches, jump and PC wrap
        imem[0]  = ins(5'b00010, 11'd9);      // LD 9
        imem[1]  = ins(5'b01001, 11'h07);     // BEQ 7 (taken)
        imem[7]  = ins(5'b01001, 11'h02);     // BEQ 2 (not taken)
        imem[8]  = ins(5'b01000, 11'h3F);     // JMP 0x3F -> 0xF
        imem[15] = ins(5'b00101, 11'd1);      // ADDI 1, PC wraps
        i_start = 1'b1; tick(); i_start = 1'b0;
        to_exec("ld", 4'd0);
        chk("ld_wait1", ctl, 7'b00_0_0_0_0_1);
        tick();
        chk("ld_wait2", {o_addr_ins, ctl}, {4'd0, 7'b00_0_0_0_0_1});
        tick();
        chk("ld_wait3", {o_addr_ins, ctl}, {4'd0, 7'b00_0_0_0_0_1});
        tick();
        i_mem_ready = 1'b1;
        #1;
        chk("ld_ready", {o_addr_ins, ctl}, {4'd0, 7'b00_0_1_0_0_1});
        tick();
        i_mem_ready = 1'b0;
        imem[0] = ins(5'b00001, 11'd4);       // STO 4, fetched after the wrap
        i_acc_zero = 1'b1;
        to_exec("beq_t", 4'd1);
        chk("beq_t_ctl", ctl, 0);
        tick();
        i_acc_zero = 1'b0;
        to_exec("beq_nt", 4'd7);
        chk("beq_nt_ctl", ctl, 0);
        tick();
        to_exec("jmp", 4'd8);
        chk("jmp_ctl", ctl, 0);
        tick();
        to_exec("addi15", 4'd15);
        chk("addi15_ctl", ctl, 7'b10_1_1_1_0_0);
        tick();
        to_exec("sto", 4'd0);
        chk("sto_wait", ctl, 7'b11_0_0_0_1_0);
        tick();
        chk("sto_wait2", {o_busy, ctl}, {1'b1, 7'b11_0_0_0_1_0});

        // Reset during STO wait, with ready and start also high on that edge
        i_rst_n = 1'b0; i_mem_ready = 1'b1; i_start = 1'b1;
        tick();
        chk("rst_mid_ctl", {o_ins_en, ctl}, 0);
        chk("rst_mid_state", {o_busy, o_halted}, 0);
        chk("rst_mid_pc", o_addr_ins, 0);
        i_rst_n = 1'b1; i_mem_ready = 1'b0; i_start = 1'b0;
        repeat (3) tick();
        chk("rst_no_fetch", {o_busy, o_ins_en, o_addr_ins}, 0);

        // Undefined opcode as NOP, HALT, restart from HALTED fetches address 0
        imem[0] = ins(5'b11111, 11'h123);
        imem[1] = ins(5'b00000, 11'd0);
        i_start = 1'b1; tick(); i_start = 1'b0;
        to_exec("nop", 4'd0);
        chk("nop_ctl", ctl, 0);
        chk("nop_data", o_data_ins, 11'h123);
        tick();
        to_exec("halt2", 4'd1);
        tick();
        chk("halt2_state", {o_halted, o_addr_ins}, {1'b1, 4'd1});
        i_start = 1'b1; tick(); i_start = 1'b0;
        chk("restart_fetch", {o_ins_en, o_halted, o_addr_ins}, {2'b10, 4'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
